// File: rtl/aes_pkg.sv
// Shared AES constants and byte-substitution tables (forward and inverse).
package aes_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] AES_AFFINE_C = 8'h63;

  // Forward S-box, row-major: entry 0 is the most significant byte.
  localparam logic [0:255][BYTE_W-1:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box for the decryption datapath.
  localparam logic [0:255][BYTE_W-1:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Forward substitution of one byte.
  function automatic logic [BYTE_W-1:0] sbox_f(input logic [BYTE_W-1:0] x);
    return SBOX[x];
  endfunction

  // Inverse substitution of one byte.
  function automatic logic [BYTE_W-1:0] inv_sbox_f(input logic [BYTE_W-1:0] x);
    return INV_SBOX[x];
  endfunction

endpackage

// File: rtl/aes_sbox_if.sv
// Byte substitution bus: input byte toward the S-box, substituted byte back.
interface aes_sbox_if;
  logic [7:0] in_toSub;
  logic [7:0] out_Subed;

  modport master (output in_toSub, input out_Subed);
  modport slave  (input in_toSub, output out_Subed);
endinterface

// File: rtl/aes_sbox_lut.sv
// Purely combinational forward S-box lookup.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] sub_c
);

  // Constant ROM lookup, fully decoded for every input value.
  always_comb begin
    sub_c = sbox_f(in_byte);
  end

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES SubBytes with a registered output and async reset.
module aes_sbox #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic    clk,
  input  logic    rst,
  aes_sbox_if.slave bus
);

  logic [7:0] sub_c;

  aes_sbox_lut u_lut (
    .in_byte (bus.in_toSub),
    .sub_c   (sub_c)
  );

  // Capture the substituted byte every edge; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_Subed <= RESET_VAL;
    end else begin
      bus.out_Subed <= sub_c;
    end
  end

endmodule

// File: tb/tb_aes_sbox.sv
// Directed and exhaustive checks of aes_sbox against a GF(2^8) reference model.
module tb_aes_sbox;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [255:0] seen;

  aes_sbox_if bus ();

  aes_sbox #(.RESET_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; it yields 0 for x = 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] o;
    b = ginv(x);
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a byte away from the edge, then check it one edge later.
  task automatic step(input string tag, input logic [7:0] v, input logic [7:0] exp);
    @(negedge clk);
    bus.in_toSub = v;
    @(posedge clk);
    #1;
    check(tag, bus.out_Subed, exp);
  endtask

  initial begin
    logic [7:0] exp_v;
    logic [7:0] got;
    n_cmp = 0;
    n_bad = 0;
    seen  = '0;
    rst   = 1'b0;
    bus.in_toSub = 8'h53;

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_immediate", bus.out_Subed, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", bus.out_Subed, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_release_no_edge", bus.out_Subed, 8'h00);

    // Known vectors.
    step("vec_00", 8'h00, 8'h63);
    step("vec_01", 8'h01, 8'h7c);
    step("vec_10", 8'h10, 8'hca);
    step("vec_53", 8'h53, 8'hed);
    step("vec_c9", 8'hc9, 8'hdd);
    step("vec_ff", 8'hff, 8'h16);

    // Back-to-back alternation, one check per cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step("alt_00", 8'h00, 8'h63);
      else            step("alt_ff", 8'hff, 8'h16);
    end

    // Exhaustive sweep with a mid-stream reset.
    for (int i = 0; i < 256; i++) begin
      exp_v = ref_sbox(8'(i));
      @(negedge clk);
      bus.in_toSub = 8'(i);
      @(posedge clk);
      #1;
      got = bus.out_Subed;
      check($sformatf("sweep_%02h", i), got, exp_v);
      n_cmp++;
      assert (!$isunknown(got)) else begin
        n_bad++;
        $error("FAIL xcheck_%02h observed=%h expected=known", i, got);
      end
      n_cmp++;
      assert (seen[got] == 1'b0) else begin
        n_bad++;
        $error("FAIL distinct_%02h observed=%h expected=unused_value", i, got);
      end
      seen[got] = 1'b1;
      if (i == 100) begin
        #2 rst = 1'b1;
        #1 check("midreset_immediate", bus.out_Subed, 8'h00);
        #1 rst = 1'b0;
        #0 check("midreset_release_hold", bus.out_Subed, 8'h00);
      end
    end
    n_cmp++;
    assert (seen == {256{1'b1}}) else begin
      n_bad++;
      $error("FAIL bijection observed=%h expected=all_ones", seen);
    end

    // Wrap from FF back to 00.
    step("wrap_00", 8'h00, 8'h63);
    step("post_53", 8'h53, 8'hed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
